fifo_stream: RTL
================

# fifo_stream

Parametrised synchronous FIFO for buffering PCM audio sample words between a capture front end and downstream consumers. Supports full power-of-two usable depth, a registered occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a strobe mode selectable between plain level strobes and falling-edge one-shots for strobes driven by buttons or slow logic.

## Interface
- ABITS, 6: address bits; DEPTH = 2^ABITS usable words.
- DBITS, 16: data word width.
- EDGE_MODE, 0: 0 = rd/wr are single-cycle enables; 1 = a transaction fires once per falling edge of rd/wr.
- AF_LEVEL, 2^ABITS-4: almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserted when count <= AE_LEVEL.

- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; deasserts synchronously to clock externally.
- wr  in  1  write strobe (level or edge per EDGE_MODE).
- rd  in  1  read strobe (level or edge per EDGE_MODE).
- flush  in  1  synchronous empty request, level, one cycle sufficient.
- clear_err  in  1  synchronous clear of overflow/underflow.
- din  in  DBITS  write data, sampled at the edge the write is performed.
- dout  out  DBITS  registered read data.
- count  out  ABITS+1  words stored, 0..DEPTH.
- empty, full, almost_empty, almost_full  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- Strobe events: EDGE_MODE=0: wr_evt = wr, rd_evt = rd. EDGE_MODE=1: two-flop sample per strobe (q1 <= strobe, q2 <= q1); evt = ~q1 & q2; one event per 1->0 transition regardless of low/high duration. Sample flops reset to 0.
- Write accepted iff wr_evt & (~full | rd_accepted). Accepted write stores din at wr_ptr, wr_ptr increments modulo DEPTH.
- Read accepted iff rd_evt & ~empty. Accepted read loads dout <= mem[rd_ptr], rd_ptr increments modulo DEPTH. dout holds its value when no read is accepted.
- Simultaneous accepted read and write: both performed, count unchanged. When full, simultaneous rd+wr both accepted (space freed the same edge). When empty, simultaneous rd+wr: write accepted, read rejected.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. Pointers ABITS bits, wrap naturally; full/empty derived from count, never from pointer equality.
- Flags combinational from registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
- overflow set on wr_evt that is rejected; underflow set on rd_evt that is rejected. Both sticky until clear_err or reset; a set and clear_err in the same cycle leaves the flag set.
- flush: highest priority; pointers and count to 0, any same-cycle rd/wr ignored and not flagged; memory contents, dout and error flags unchanged.
- Memory array is not reset.

## Timing
- Reset (reset=0): count 0, pointers 0, dout 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0; takes effect immediately, independent of clock. Reset mid-transfer discards all contents.
- EDGE_MODE=0: strobe high at edge N -> count/flags/dout updated after edge N; read latency 1 cycle.
- EDGE_MODE=1: strobe sampled low at edge N after high at N-1 -> transaction performed at edge N+1; dout/count valid after N+1. din must be stable at edge N+1.
- Write to read-out: data written at edge N readable by a read accepted at edge N+1 or later (no bypass).
- Throughput: one read and one write per cycle in EDGE_MODE=0.

## Test plan
- Reset then 64 writes (ABITS=6, EDGE_MODE=0, din=0..63) -> count=64, full=1 after 64th; 65th write -> overflow=1, count stays 64; 64 reads return 0..63 in order, empty=1 at end.
- Read on empty after reset -> underflow=1, dout=0, count=0; clear_err pulse -> underflow=0.
- Fill to 64, hold rd=wr=1 for 200 cycles with incrementing din -> count stays 64, no overflow, dout sequence contiguous across pointer wrap.
- Thresholds: writes to 60 -> almost_full rises on the 60th; reads to 4 -> almost_empty rises when count=4.
- EDGE_MODE=1: hold wr high 10 cycles then low 10 cycles, twice -> exactly 2 writes, each performed 2 edges after the falling edge sample; count=2.
- Count=30, assert flush with rd=wr=1 same cycle -> count=0, empty=1, no error flags; async reset mid-burst -> all outputs to reset values before next clock edge.

Source files
------------

// File: rtl/fifo_stream.sv
// Synchronous sample FIFO with registered occupancy count, threshold flags,
// sticky overflow/underflow and optional falling-edge strobe detection.
module fifo_stream #(
  parameter int ABITS     = 6,
  parameter int DBITS     = 16,
  parameter int EDGE_MODE = 0,
  parameter int AF_LEVEL  = (1 << ABITS) - 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic             flush,
  input  logic             clear_err,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic [ABITS:0]   count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ABITS;
  localparam logic [ABITS:0] FULL_CNT = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_CNT   = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0] AE_CNT   = (ABITS+1)'(AE_LEVEL);

  logic [DBITS-1:0] mem [DEPTH];
  logic [ABITS-1:0] wr_ptr, rd_ptr;
  logic             wr_evt, rd_evt;
  logic             wr_acc, rd_acc;
  logic             wr_rej, rd_rej;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic wr_q1, wr_q2, rd_q1, rd_q2;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wr_q1 <= 1'b0;
          wr_q2 <= 1'b0;
          rd_q1 <= 1'b0;
          rd_q2 <= 1'b0;
        end else begin
          // NOTE: non-blocking so q2 takes the old q1, giving a true two-stage sample.
          wr_q1 <= wr;
          wr_q2 <= wr_q1;
          rd_q1 <= rd;
          rd_q2 <= rd_q1;
        end
      end

      assign wr_evt = ~wr_q1 & wr_q2;
      assign rd_evt = ~rd_q1 & rd_q2;
    end else begin : g_level
      assign wr_evt = wr;
      assign rd_evt = rd;
    end
  endgenerate

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A read frees a slot on the same edge, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_evt & ~empty & ~flush;
  assign wr_acc = wr_evt & (~full | rd_acc) & ~flush;
  assign rd_rej = rd_evt & ~rd_acc & ~flush;
  assign wr_rej = wr_evt & ~wr_acc & ~flush;

  // NOTE: the sample array has no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // A new error in the same cycle as clear_err wins.
      overflow  <= (overflow  & ~clear_err) | wr_rej;
      underflow <= (underflow & ~clear_err) | rd_rej;
    end
  end

endmodule
